// File: rtl/popcount_seq_pkg.sv
// Shared definitions for the sequential popcount engine: FSM encoding,
// slice width and a constant-foldable clog2 used to size counters.
package popcount_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SLICE_W = 8;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_seq_core.sv
// Combinational 8-bit population count; the single datapath shared across
// all slices of a wide word.
module popcount8_core (
  input  logic [7:0] in_byte,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      count = count + {3'b000, in_byte[i]};
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Wide-word popcount: accepts one word, walks its byte slices LSB-first
// through one popcount8_core, and presents the accumulated total.
module popcount_seq
  import popcount_seq_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  localparam int unsigned NSLICE = WIDTH / SLICE_W,
  localparam int unsigned CW     = clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned IDX_W = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CW-1:0]      acc_q,   acc_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [3:0]         slice_count;

  popcount8_core u_pc8 (
    .in_byte (shift_q[SLICE_W-1:0]),
    .count   (slice_count)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        acc_d   = acc_q + CW'(slice_count);
        shift_d = shift_q >> SLICE_W;
        idx_d   = idx_q + IDX_W'(1);
        // Fixed NSLICE cycles: no early exit when the remainder is zero.
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_count = acc_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Sequential population-count engine for words wider than 8 bits.
- Accepts one WIDTH-bit word over a valid/ready handshake and time-multiplexes a single shared 8-bit popcount datapath across the word's byte slices, least significant slice first.
- Accumulates the per-slice counts and presents the total on a valid/ready output.
- Sits between a word producer and a count consumer; lets wide-word popcount reuse one PopCount8 instance instead of replicating adder trees.

Parameters:
- WIDTH, 32, input word width in bits; must be a multiple of 8 and >= 16.
- NSLICE, WIDTH/8, derived; number of 8-bit slices per word, not overridable.
- CW, clog2(WIDTH+1), derived; width of the count output (6 for WIDTH=32).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to count; sampled only on the accept cycle.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word (high only in IDLE).
- out_count  output  CW  number of set bits in the accepted word.
- out_valid  output  1  out_count is valid (high only in DONE).
- out_ready  input  1  consumer takes out_count.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (CLK); reset (RESET) is synchronous and active-high.
- Reset: state=IDLE, shift register=0, acc=0, slice index=0. Outputs: in_ready=1, out_valid=0, out_count=0, busy=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - If in_valid, the word is accepted: shift<=in_data, acc<=0, idx<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc<=acc+pc8(shift[7:0]), shift<=shift>>8, idx<=idx+1.
  - When idx==NSLICE-1, the final slice is added that cycle and the state goes to DONE.
  - No early exit on zero remainder: fixed NSLICE cycles in RUN.
- DONE:
  - out_valid=1; out_count=acc, held stable until the handshake.
  - If out_ready, go to IDLE and clear acc the same edge.
  - No new word is accepted in DONE.
- Latency: word accepted at edge T; out_valid rises after edge T+NSLICE, i.e. NSLICE+1 cycles after accept (5 for WIDTH=32).
- Throughput: at most one word per NSLICE+2 cycles with out_ready held high.
- Arithmetic:
  - pc8 result is 4 bits, zero-extended to CW before the add.
  - acc is CW bits and cannot overflow, since the maximum is WIDTH.
- Boundary conditions:
  - in_valid while not in IDLE: ignored (in_ready=0); in_data is not sampled.
  - in_data changing during RUN: no effect.
  - out_ready high outside DONE: ignored.
  - RESET asserted in RUN or DONE: the in-flight word is dropped, no out_valid pulse, and the block is back in IDLE on the next cycle.
  - RESET has priority over every handshake in the same cycle.
- out_count outside DONE: holds the last acc value, and consumers must qualify it with out_valid. After reset it is 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the slice width constant SLICE_W=8;
  - a clog2 function for CW.
- One sub-module: popcount8_core, a combinational 8-bit-in, 4-bit-out popcount, instantiated once.
- The FSM, shift register, index counter and accumulator live in popcount_seq.

Test Plan (WIDTH=32):
- Reset then in_data=0xFFFFFFFF, in_valid for 1 cycle, out_ready=1 -> in_ready falls next cycle; out_valid high 5 cycles after accept with out_count=32; back to IDLE the cycle after.
- in_data=0x00000000 -> out_count=0.
- in_data=0x80000001 -> out_count=2.
- in_data=0x0F0F00FF -> out_count=16, exercising all slices.
- Backpressure: in_data=0x12345678, out_ready=0 for 10 cycles after out_valid -> out_valid and out_count=13 stay stable; completes the cycle out_ready rises.
- Busy rejection and reset:
  - Hold in_valid high with changing data during RUN -> data is not accepted and the result matches the first word only.
  - RESET pulsed during the third RUN cycle -> out_valid is never asserted, and in_ready=1, busy=0, out_count=0 the next cycle.
